// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-side bundle between the ID/EX stages and the hazard
//               and redirect controller. The master is the pipeline; the slave
//               is the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int XLEN = 32
);
    logic [4:0]      ID_rs1;
    logic [4:0]      ID_rs2;
    logic            ID_rs1_vld;
    logic            ID_rs2_vld;
    logic [4:0]      ID_REG_rd;
    logic [6:0]      ID_REG_opcode;
    logic            ID_jmp_vld;
    logic [XLEN-1:0] ID_imm;
    logic [XLEN-1:0] ID_pc;
    logic            EX_jmp_vld;
    logic [XLEN-1:0] EX_jmp_addr;
    logic            hold_IF;
    logic            CTRL_IF_jmp_vld;
    logic [XLEN-1:0] CTRL_IF_jmp_addr;
    logic            CTRL_EX_en;

    modport master (
        output ID_rs1, ID_rs2, ID_rs1_vld, ID_rs2_vld, ID_REG_rd, ID_REG_opcode,
               ID_jmp_vld, ID_imm, ID_pc, EX_jmp_vld, EX_jmp_addr,
        input  hold_IF, CTRL_IF_jmp_vld, CTRL_IF_jmp_addr, CTRL_EX_en
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rs1_vld, ID_rs2_vld, ID_REG_rd, ID_REG_opcode,
               ID_jmp_vld, ID_imm, ID_pc, EX_jmp_vld, EX_jmp_addr,
        output hold_IF, CTRL_IF_jmp_vld, CTRL_IF_jmp_addr, CTRL_EX_en
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall and branch/jump redirect controller for the
//               RV32 in-order core. Two independent down-counters track the
//               load-use stall and the post-branch flush window.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int XLEN       = 32,
    parameter int LOAD_STALL = 1,
    parameter int BR_FLUSH   = 2
) (
    input  wire               clk,
    input  wire               rst,
    hazard_ctrl_if.slave      bus
);
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [2:0] c_LU_RELOAD  = 3'(LOAD_STALL);
    localparam logic [2:0] c_FL_RELOAD  = 3'(BR_FLUSH - 1);

    logic [2:0] r_lu_cnt;
    logic [2:0] r_fl_cnt;

    logic w_src_match;
    logic w_lu_hit;
    logic w_hold;
    logic w_fl_idle;

    // Load-use detection against the instruction sitting in ID/EX; x0 never
    // creates a dependency, and a taken EX branch makes the ID op wrong-path.
    always_comb begin
        w_src_match = ((bus.ID_rs1 == bus.ID_REG_rd) && bus.ID_rs1_vld) ||
                      ((bus.ID_rs2 == bus.ID_REG_rd) && bus.ID_rs2_vld);
        w_lu_hit    = w_src_match &&
                      (bus.ID_REG_rd != 5'd0) &&
                      (bus.ID_REG_opcode == c_OPC_LOAD) &&
                      (r_lu_cnt == 3'd0) &&
                      !bus.EX_jmp_vld &&
                      !rst;
        w_hold      = !rst && (w_lu_hit || (r_lu_cnt > 3'd1));
        w_fl_idle   = (r_fl_cnt == 3'd0);
    end

    // Stall and flush counters; a taken EX branch cancels a pending stall and
    // (re)starts the flush window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_cnt <= 3'd0;
            r_fl_cnt <= 3'd0;
        end else begin
            if (bus.EX_jmp_vld) begin
                r_lu_cnt <= 3'd0;
            end else if (w_lu_hit) begin
                r_lu_cnt <= c_LU_RELOAD;
            end else if (r_lu_cnt != 3'd0) begin
                r_lu_cnt <= r_lu_cnt - 3'd1;
            end

            if (bus.EX_jmp_vld) begin
                r_fl_cnt <= c_FL_RELOAD;
            end else if (r_fl_cnt != 3'd0) begin
                r_fl_cnt <= r_fl_cnt - 3'd1;
            end
        end
    end

    // Redirect arbitration: EX branch wins; an ID jump fires only when it is
    // on the correct path and not frozen, so it issues exactly once.
    always_comb begin
        bus.CTRL_IF_jmp_vld  = 1'b0;
        bus.CTRL_IF_jmp_addr = '0;
        if (!rst) begin
            if (bus.EX_jmp_vld) begin
                bus.CTRL_IF_jmp_vld  = 1'b1;
                bus.CTRL_IF_jmp_addr = bus.EX_jmp_addr;
            end else if (bus.ID_jmp_vld && w_fl_idle && !w_hold) begin
                bus.CTRL_IF_jmp_vld  = 1'b1;
                bus.CTRL_IF_jmp_addr = bus.ID_pc + bus.ID_imm;
            end
        end
    end

    // Stage enables: IF/ID freeze and EX bubble insertion.
    always_comb begin
        bus.hold_IF    = w_hold;
        bus.CTRL_EX_en = !rst && !bus.EX_jmp_vld && w_fl_idle && (r_lu_cnt == 3'd0);
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard and redirect controller for the RV32 in-order core; successor to the fixed single-stall / two-bubble control unit.
- Detects load-use hazards between ID and the ID/EX register and stalls IF/ID for a configurable number of cycles.
- Arbitrates EX (conditional) and ID (unconditional) redirects to IF, and inserts a configurable number of EX bubbles after a taken EX branch.
- New over the previous generation: x0 hazard exclusion, wrong-path ID-jump suppression, single-shot ID redirect under stall, and a defined reset.

Parameters:
- XLEN, 32, width of PC, immediate and redirect address.
- LOAD_STALL, 1, stall cycles per load-use hazard (legal 1..7).
- BR_FLUSH, 2, EX bubbles per taken EX branch, including the branch cycle (legal 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ID_rs1  in  5  ID source register 1
- ID_rs2  in  5  ID source register 2
- ID_rs1_vld  in  1  rs1 is read by the ID instruction
- ID_rs2_vld  in  1  rs2 is read by the ID instruction
- ID_REG_rd  in  5  rd of the instruction in the ID/EX register
- ID_REG_opcode  in  7  opcode of the instruction in the ID/EX register
- ID_jmp_vld  in  1  ID holds an unconditional jump
- ID_imm  in  XLEN  jump immediate
- ID_pc  in  XLEN  PC of the ID instruction
- EX_jmp_vld  in  1  EX conditional branch taken
- EX_jmp_addr  in  XLEN  EX branch target
- hold_IF  out  1  freeze PC and IF/ID
- CTRL_IF_jmp_vld  out  1  redirect IF this cycle
- CTRL_IF_jmp_addr  out  XLEN  redirect target
- CTRL_EX_en  out  1  EX may commit; 0 = bubble

Behaviour:
- Internal state: lu_cnt (3b) and fl_cnt (3b); both 0 after reset. State is IDLE when both counters are 0, LU_STALL when lu_cnt>0, FLUSH when fl_cnt>0.
- Outputs during rst: hold_IF=0, CTRL_IF_jmp_vld=0, CTRL_IF_jmp_addr=0, CTRL_EX_en=0. Counters clear on the same edge.
- Load-use detect (combinational), lu_hit = all of:
  - (ID_rs1==ID_REG_rd && ID_rs1_vld) || (ID_rs2==ID_REG_rd && ID_rs2_vld)
  - ID_REG_rd != 0
  - ID_REG_opcode == 7'b0000011
  - lu_cnt == 0
  - !EX_jmp_vld
  - !rst
- hold_IF = lu_hit || (lu_cnt > 1).
- lu_cnt next value:
  - rst or EX_jmp_vld: 0
  - lu_hit: LOAD_STALL
  - lu_cnt>0: lu_cnt-1
- Resulting load-use timing, with lu_hit in cycle T:
  - hold_IF high over cycles T .. T+LOAD_STALL-1.
  - CTRL_EX_en low over T+1 .. T+LOAD_STALL.
  - No re-detection until T+LOAD_STALL+1.
- fl_cnt next value:
  - rst: 0
  - EX_jmp_vld: BR_FLUSH-1 (reloads even if already >0)
  - fl_cnt>0: fl_cnt-1
- CTRL_EX_en = !rst && !EX_jmp_vld && fl_cnt==0 && lu_cnt==0.
- Redirect priority (combinational, same cycle):
  - EX_jmp_vld: CTRL_IF_jmp_vld=1, CTRL_IF_jmp_addr=EX_jmp_addr.
  - Else if ID_jmp_vld && fl_cnt==0 && !hold_IF: CTRL_IF_jmp_vld=1, CTRL_IF_jmp_addr=ID_pc+ID_imm (mod 2^XLEN, carry dropped).
  - Else: CTRL_IF_jmp_vld=0, CTRL_IF_jmp_addr=0.
- ID jump suppression rules:
  - Suppressed while fl_cnt>0, since the ID instruction is wrong-path.
  - Suppressed while hold_IF=1, so the redirect fires once, in the first un-held cycle.
- Simultaneous events:
  - EX_jmp_vld overrides a load-use hit and cancels any stall in progress.
  - A load-use hit during FLUSH is still legal (lu_cnt and fl_cnt run independently); CTRL_EX_en is the AND of both.
- Reset mid-operation clears a stall or flush within one edge. Outputs resume normal behaviour on the first cycle with rst=0.

Test Plan:
- Load-use, LOAD_STALL=1: ID_REG_opcode=0x03, ID_REG_rd=5, ID_rs1=5, rs1_vld=1 at T -> hold_IF=1 at T only; CTRL_EX_en=0 at T+1 only.
- Load-use, LOAD_STALL=3, same stimulus -> hold_IF high T..T+2; CTRL_EX_en low T+1..T+3. With rd=0 instead -> no hold and no bubble.
- EX branch, BR_FLUSH=2: EX_jmp_vld=1, EX_jmp_addr=0x100 at T -> redirect to 0x100 at T; CTRL_EX_en low at T and T+1. ID_jmp_vld=1 at T+1 -> no redirect.
- ID jump: ID_pc=0xFFFFFFF0, ID_imm=0x20 with no hazard -> CTRL_IF_jmp_vld=1, addr=0x10 (wrap). Same jump during a 2-cycle load stall -> exactly one redirect pulse, in the first cycle hold_IF=0.
- Simultaneous: lu_hit conditions and EX_jmp_vld=1 (addr 0x200) at T -> hold_IF=0, redirect to 0x200, CTRL_EX_en low at T and T+1 only.
- Reset: assert rst during cycle 2 of a LOAD_STALL=3 stall -> next cycle hold_IF=0; CTRL_EX_en=1 after rst drops; no residual bubble.
